// File: rtl/phase_check_sequencer.sv
// Time-shares one phase-shift checker across the PLL clock outputs and collects a fail bitmap.
// Optional lock-wait timeout is enabled by defining PHASE_SEQ_TIMEOUT_EN.
module phase_check_sequencer #(
   parameter int CHANNELS      = 6,
   parameter int SETTLE_CYCLES = 16,
   parameter int WINDOW_CYCLES = 64,
   parameter int LOCK_TIMEOUT  = 4096,
   localparam int SEL_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    LOCKED,
   input  logic [CHANNELS-1:0]     channel_en,
   input  logic [32*CHANNELS-1:0]  shift_table,
   input  logic [32*CHANNELS-1:0]  period_table,
   input  logic                    check_fail,
   output logic [SEL_W-1:0]        sel,
   output logic [31:0]             desired_shift_1000,
   output logic [31:0]             clk_period_1000,
   output logic                    check_rst,
   output logic                    check_locked,
   output logic                    busy,
   output logic                    done,
   output logic [CHANNELS-1:0]     fail_mask,
   output logic                    lock_lost,
   output logic                    timeout,
   output logic [2:0]              dbg_state_o
);

   localparam int CNT_MAX_A = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
   localparam int CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT) ? CNT_MAX_A : LOCK_TIMEOUT;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_LOCK, S_ARM, S_SETTLE, S_MEASURE, S_NEXT, S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [SEL_W-1:0]     ch_q, ch_d;
   logic [CHANNELS-1:0]  en_q, en_d;
   logic [31:0]          shift_tab_q [CHANNELS];
   logic [31:0]          period_tab_q [CHANNELS];
   logic                 tab_load;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [SEL_W-1:0]     sel_q, sel_d;
   logic [31:0]          dshift_q, dshift_d;
   logic [31:0]          dper_q, dper_d;
   logic [CHANNELS-1:0]  fail_mask_q, fail_mask_d;
   logic                 lock_lost_q, lock_lost_d;
   logic [SEL_W-1:0]     first_idx, next_idx;
   logic                 first_vld, next_vld;
`ifdef PHASE_SEQ_TIMEOUT_EN
   logic                 timeout_q, timeout_d;
   logic [CHANNELS-1:0]  rem_mask;
`endif

   // Lowest enabled channel at start, and next enabled channel strictly above ch_q.
   always_comb begin
      first_idx = '0;
      first_vld = 1'b0;
      next_idx  = '0;
      next_vld  = 1'b0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (channel_en[i]) begin
            first_idx = SEL_W'(i);
            first_vld = 1'b1;
         end
         if (en_q[i] && (i > int'(ch_q))) begin
            next_idx = SEL_W'(i);
            next_vld = 1'b1;
         end
      end
   end

`ifdef PHASE_SEQ_TIMEOUT_EN
   always_comb begin
      rem_mask = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         rem_mask[i] = en_q[i] && (i >= int'(ch_q));
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         ch_q        <= '0;
         en_q        <= '0;
         cnt_q       <= '0;
         sel_q       <= '0;
         dshift_q    <= '0;
         dper_q      <= '0;
         fail_mask_q <= '0;
         lock_lost_q <= 1'b0;
`ifdef PHASE_SEQ_TIMEOUT_EN
         timeout_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         en_q        <= en_d;
         cnt_q       <= cnt_d;
         sel_q       <= sel_d;
         dshift_q    <= dshift_d;
         dper_q      <= dper_d;
         fail_mask_q <= fail_mask_d;
         lock_lost_q <= lock_lost_d;
`ifdef PHASE_SEQ_TIMEOUT_EN
         timeout_q   <= timeout_d;
`endif
      end
   end

   assign tab_load = (state_q == S_IDLE) && start;

   always_ff @(posedge clk) begin
      if (tab_load) begin
         for (int i = 0; i < CHANNELS; i++) begin
            shift_tab_q[i]  <= shift_table[32*i +: 32];
            period_tab_q[i] <= period_table[32*i +: 32];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      en_d        = en_q;
      cnt_d       = cnt_q;
      sel_d       = sel_q;
      dshift_d    = dshift_q;
      dper_d      = dper_q;
      fail_mask_d = fail_mask_q;
      lock_lost_d = lock_lost_q;
`ifdef PHASE_SEQ_TIMEOUT_EN
      timeout_d   = timeout_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               en_d        = channel_en;
               fail_mask_d = '0;
               lock_lost_d = 1'b0;
`ifdef PHASE_SEQ_TIMEOUT_EN
               timeout_d   = 1'b0;
`endif
               ch_d        = first_idx;
               cnt_d       = '0;
               state_d     = first_vld ? S_WAIT_LOCK : S_DONE;
            end
         end
         S_WAIT_LOCK: begin
            if (LOCKED) begin
               state_d = S_ARM;
            end
`ifdef PHASE_SEQ_TIMEOUT_EN
            else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
               timeout_d   = 1'b1;
               fail_mask_d = fail_mask_q | rem_mask;
               state_d     = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         S_ARM: begin
            sel_d    = ch_q;
            dshift_d = shift_tab_q[ch_q];
            dper_d   = period_tab_q[ch_q];
            cnt_d    = CNT_W'(SETTLE_CYCLES - 1);
            state_d  = S_SETTLE;
         end
         S_SETTLE, S_MEASURE: begin
            // Lock loss aborts the attempt; the same channel is retried after relock.
            if (!LOCKED) begin
               lock_lost_d       = 1'b1;
               fail_mask_d[ch_q] = 1'b0;
               cnt_d             = '0;
               state_d           = S_WAIT_LOCK;
            end else if (state_q == S_SETTLE) begin
               if (cnt_q == '0) begin
                  cnt_d   = CNT_W'(WINDOW_CYCLES - 1);
                  state_d = S_MEASURE;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end else begin
               if (check_fail) fail_mask_d[ch_q] = 1'b1;
               if (cnt_q == '0) begin
                  state_d = S_NEXT;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end
         S_NEXT: begin
            if (next_vld) begin
               ch_d    = next_idx;
               state_d = S_ARM;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      check_rst    = !((state_q == S_SETTLE) || (state_q == S_MEASURE));
      check_locked = (state_q == S_MEASURE);
      busy         = (state_q != S_IDLE);
      done         = (state_q == S_DONE);
   end

   assign sel                = sel_q;
   assign desired_shift_1000 = dshift_q;
   assign clk_period_1000    = dper_q;
   assign fail_mask          = fail_mask_q;
   assign lock_lost          = lock_lost_q;
   assign dbg_state_o        = state_q;
`ifdef PHASE_SEQ_TIMEOUT_EN
   assign timeout            = timeout_q;
`else
   assign timeout            = 1'b0;
`endif

endmodule

// File: tb/tb_phase_check_sequencer.sv
// Directed bench for phase_check_sequencer: sweep timing, fail capture, lock loss, timeout, reset.
module tb_phase_check_sequencer;

   localparam int CH = 6;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            start = 1'b0;
   logic            LOCKED = 1'b1;
   logic [CH-1:0]   channel_en = '0;
   logic [32*CH-1:0] shift_table = '0;
   logic [32*CH-1:0] period_table = '0;
   logic            check_fail = 1'b0;
   logic [2:0]      sel;
   logic [31:0]     desired_shift_1000;
   logic [31:0]     clk_period_1000;
   logic            check_rst;
   logic            check_locked;
   logic            busy;
   logic            done;
   logic [CH-1:0]   fail_mask;
   logic            lock_lost;
   logic            timeout;
   logic [2:0]      dbg_state_o;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0]     s_ref [CH];
   logic [31:0]     p_ref [CH];
   logic [32*CH-1:0] shift_pk;
   logic [32*CH-1:0] period_pk;
   logic [2:0]      exp_q[$];
   int              dcyc;

   phase_check_sequencer #(
      .CHANNELS(CH), .SETTLE_CYCLES(16), .WINDOW_CYCLES(64), .LOCK_TIMEOUT(100)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .LOCKED(LOCKED), .channel_en(channel_en),
      .shift_table(shift_table), .period_table(period_table), .check_fail(check_fail),
      .sel(sel), .desired_shift_1000(desired_shift_1000), .clk_period_1000(clk_period_1000),
      .check_rst(check_rst), .check_locked(check_locked), .busy(busy), .done(done),
      .fail_mask(fail_mask), .lock_lost(lock_lost), .timeout(timeout), .dbg_state_o(dbg_state_o)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, "_sel"}, 32'(sel), 32'd0);
      check_eq({tag, "_shift"}, desired_shift_1000, 32'd0);
      check_eq({tag, "_period"}, clk_period_1000, 32'd0);
      check_eq({tag, "_check_rst"}, 32'(check_rst), 32'd1);
      check_eq({tag, "_check_locked"}, 32'(check_locked), 32'd0);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_done"}, 32'(done), 32'd0);
      check_eq({tag, "_fail_mask"}, 32'(fail_mask), 32'd0);
      check_eq({tag, "_lock_lost"}, 32'(lock_lost), 32'd0);
      check_eq({tag, "_timeout"}, 32'(timeout), 32'd0);
      check_eq({tag, "_state"}, 32'(dbg_state_o), 32'd0);
   endtask

   function automatic logic lk_at(int cyc, int s, int l);
      return !((cyc >= s) && (cyc < s + l));
   endfunction

   // Cycle 0 is the start cycle; returns the cycle in which done was seen, or -1.
   task automatic run_sweep(input logic [CH-1:0] en, input int fail_cyc, input int lk_s,
                            input int lk_l, input int restart_cyc, input int rst_cyc,
                            input int limit, output int done_cyc);
      int exp_n;
      int visits;
      logic prev_cl;
      logic [2:0] e;
      done_cyc = -1;
      exp_n = exp_q.size();
      visits = 0;
      prev_cl = 1'b0;
      channel_en = en;
      shift_table = shift_pk;
      period_table = period_pk;
      LOCKED = lk_at(0, lk_s, lk_l);
      start = 1'b1;
      step();
      start = 1'b0;
      channel_en = ~en;
      shift_table = ~shift_pk;
      period_table = ~period_pk;
      for (int cyc = 1; cyc <= limit; cyc++) begin
         check_fail = (cyc == fail_cyc);
         LOCKED = lk_at(cyc, lk_s, lk_l);
         start = (cyc == restart_cyc);
         if (check_locked && !prev_cl) begin
            visits++;
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check_eq("visit_sel", 32'(sel), 32'(e));
               check_eq("visit_shift", desired_shift_1000, s_ref[e]);
               check_eq("visit_period", clk_period_1000, p_ref[e]);
            end
         end
         prev_cl = check_locked;
         if (cyc == rst_cyc) begin
            rst = 1'b0;
            step();
            rst = 1'b1;
            break;
         end
         if (done) begin
            done_cyc = cyc;
            break;
         end
         step();
      end
      check_eq("visit_count", 32'(visits), 32'(exp_n));
      exp_q.delete();
      start = 1'b0;
      check_fail = 1'b0;
      LOCKED = 1'b1;
      channel_en = en;
      shift_table = shift_pk;
      period_table = period_pk;
   endtask

   task automatic finish_sweep(input string tag, input int done_cyc, input int exp_cyc,
                               input logic [CH-1:0] exp_mask, input logic exp_ll,
                               input logic exp_to);
      check_eq({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_cyc));
      check_eq({tag, "_fail_mask"}, 32'(fail_mask), 32'(exp_mask));
      check_eq({tag, "_lock_lost"}, 32'(lock_lost), 32'(exp_ll));
      check_eq({tag, "_timeout"}, 32'(timeout), 32'(exp_to));
      check_eq({tag, "_busy_in_done"}, 32'(busy), 32'd1);
      step();
      check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
      check_eq({tag, "_busy_after"}, 32'(busy), 32'd0);
      check_eq({tag, "_mask_hold"}, 32'(fail_mask), 32'(exp_mask));
   endtask

   initial begin
      for (int i = 0; i < CH; i++) begin
         s_ref[i] = 32'(i * 1500) - 32'd4000;
         p_ref[i] = 32'd10000 + 32'(i * 250);
         shift_pk[32*i +: 32] = s_ref[i];
         period_pk[32*i +: 32] = p_ref[i];
      end

      rst = 1'b0;
      repeat (3) step();
      check_idle("reset");
      rst = 1'b1;
      step();

      exp_q = '{3'd0, 3'd2, 3'd5};
      run_sweep(6'b100101, -1, 0, 0, -1, -1, 400, dcyc);
      finish_sweep("basic", dcyc, 248, 6'b000000, 1'b0, 1'b0);

      exp_q = '{3'd0, 3'd2, 3'd5};
      run_sweep(6'b100101, 164, 0, 0, -1, -1, 400, dcyc);
      finish_sweep("fail_last_meas", dcyc, 248, 6'b000100, 1'b0, 1'b0);

      exp_q = '{3'd0, 3'd2, 3'd5};
      run_sweep(6'b100101, 165, 0, 0, -1, -1, 400, dcyc);
      finish_sweep("fail_in_next", dcyc, 248, 6'b000000, 1'b0, 1'b0);

      exp_q = '{3'd0, 3'd0, 3'd2, 3'd5};
      run_sweep(6'b100101, 30, 40, 5, -1, -1, 400, dcyc);
      finish_sweep("lock_loss", dcyc, 292, 6'b000000, 1'b1, 1'b0);

      run_sweep(6'b000000, -1, 0, 0, -1, -1, 20, dcyc);
      finish_sweep("no_channels", dcyc, 1, 6'b000000, 1'b0, 1'b0);

      exp_q = '{3'd0, 3'd2, 3'd5};
      run_sweep(6'b100101, 164, 0, 0, 50, -1, 400, dcyc);
      finish_sweep("restart_ignored", dcyc, 248, 6'b000100, 1'b0, 1'b0);

      exp_q = '{3'd5};
      run_sweep(6'b100000, -1, 0, 0, -1, -1, 200, dcyc);
      finish_sweep("top_channel", dcyc, 84, 6'b000000, 1'b0, 1'b0);

`ifdef PHASE_SEQ_TIMEOUT_EN
      run_sweep(6'b000011, -1, 0, 1000000, -1, -1, 300, dcyc);
      finish_sweep("timeout", dcyc, 101, 6'b000011, 1'b0, 1'b1);
`else
      run_sweep(6'b000011, -1, 0, 1000000, -1, -1, 150, dcyc);
      check_eq("wait_forever_done", 32'(dcyc), 32'hFFFF_FFFF);
      check_eq("wait_forever_busy", 32'(busy), 32'd1);
      check_eq("wait_forever_timeout", 32'(timeout), 32'd0);
      check_eq("wait_forever_state", 32'(dbg_state_o), 32'd1);
      rst = 1'b0;
      step();
      rst = 1'b1;
      check_idle("reset_in_wait");
`endif

      exp_q = '{3'd2};
      run_sweep(6'b100100, 50, 0, 0, -1, 90, 400, dcyc);
      check_idle("reset_mid_settle");
      step();
      check_idle("idle_after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/phase_check_sequencer.md
# phase_check_sequencer

Controller that sweeps the phase-shift checker across the clock outputs of a simulated PLL. One checker instance is time-shared over up to CHANNELS outputs. For each enabled channel, the sequencer muxes that channel's shifted clock, loads its desired shift and period, resets and arms the checker once the PLL is locked, and collects the checker's fail flag. The result of a sweep is a per-channel fail bitmap. It sits in the testbench harness between the PLL model, an external clock mux and the checker.

## Interface
- CHANNELS, 6: number of PLL outputs under test (2..32).
- SETTLE_CYCLES, 16: clk cycles between checker reset release and arming.
- WINDOW_CYCLES, 64: clk cycles the checker stays armed per channel.
- LOCK_TIMEOUT, 4096: clk cycles allowed in WAIT_LOCK (only with timeout feature).

- clk  in  1  reference clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  begin sweep; sampled only in IDLE.
- LOCKED  in  1  PLL lock indicator.
- channel_en  in  CHANNELS  channels to check; captured at start.
- shift_table  in  32*CHANNELS  signed desired shift ×1000 per channel; channel i is bits [32i+31:32i]; captured at start.
- period_table  in  32*CHANNELS  clock period ×1000 per channel; captured at start.
- check_fail  in  1  checker fail flag.
- sel  out  $clog2(CHANNELS)  mux select for the checker's shifted clock.
- desired_shift_1000  out  32  to checker.
- clk_period_1000  out  32  to checker.
- check_rst  out  1  active-high checker reset.
- check_locked  out  1  drives the checker's LOCKED input.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at end of sweep.
- fail_mask  out  CHANNELS  bit i set means channel i failed.
- lock_lost  out  1  sticky per sweep; set if LOCKED falls during SETTLE or MEASURE.
- timeout  out  1  sticky per sweep; lock wait expired.

## Operation
- Reset values:
  - sel=0, desired_shift_1000=0, clk_period_1000=0, check_rst=1, check_locked=0, busy=0, done=0, fail_mask=0, lock_lost=0, timeout=0.
  - FSM returns to IDLE and all counters clear. Reset wins over every other event.
- IDLE:
  - check_rst=1.
  - On start: capture the tables and channel_en, clear fail_mask, lock_lost and timeout, set ch to the lowest enabled channel.
  - Go to WAIT_LOCK. If channel_en==0, go to DONE instead.
- WAIT_LOCK: check_rst=1. When LOCKED=1, go to ARM.
- ARM (1 cycle):
  - sel=ch; desired_shift_1000 and clk_period_1000 take channel ch's entries.
  - check_rst=1. Go to SETTLE.
- SETTLE:
  - check_rst=0, check_locked=0. Count SETTLE_CYCLES, then go to MEASURE.
- MEASURE:
  - check_locked=1 for WINDOW_CYCLES cycles.
  - Any cycle with check_fail=1 sets fail_mask[ch].
  - At the end, go to NEXT.
- LOCKED falling during SETTLE or MEASURE:
  - Set lock_lost, discard any fail recorded for ch in this attempt, and go to WAIT_LOCK.
  - The same channel is retried.
- NEXT (1 cycle):
  - check_locked=0, check_rst=1.
  - Advance ch to the next higher enabled channel and go to ARM. There is no wrap-around; if no channel remains, go to DONE.
- DONE (1 cycle): done=1, busy=0 next cycle, go to IDLE. Outputs hold until the next start.
- start while busy is ignored.

## Timing
- start sampled in cycle 0; busy=1 from cycle 1.
- Per channel with LOCKED held high: 1 (ARM) + SETTLE_CYCLES + WINDOW_CYCLES + 1 (NEXT) cycles.
- Full sweep of k enabled channels with LOCKED already high: done asserts in cycle 2 + k·(2+SETTLE_CYCLES+WINDOW_CYCLES).
- channel_en==0: done asserts in cycle 1.
- sel, desired_shift_1000 and clk_period_1000 change only on the ARM→SETTLE edge. They are stable at least SETTLE_CYCLES before check_locked rises.
- check_fail is registered and sampled on the same edge that decrements the window counter. A fail on the final MEASURE cycle counts.

## Configuration
- PHASE_SEQ_TIMEOUT_EN defined:
  - A WAIT_LOCK counter is implemented. After LOCK_TIMEOUT cycles without LOCKED, set timeout.
  - Set fail_mask for ch and for all remaining enabled channels, then go to DONE.
- Undefined: WAIT_LOCK waits indefinitely; timeout is tied to 0.

## Test plan
- CHANNELS=6, SETTLE=16, WINDOW=64, channel_en=6'b100101, LOCKED=1, check_fail=0, start → sel visits 0, 2, 5; done in cycle 248; fail_mask=0.
- Same setup, check_fail pulsed one cycle during channel 2's last MEASURE cycle → fail_mask=6'b000100.
- LOCKED dropped for 5 cycles mid-MEASURE on channel 0 → lock_lost=1; channel 0 re-armed after LOCKED returns; stale fail discarded; done delayed accordingly.
- PHASE_SEQ_TIMEOUT_EN, LOCK_TIMEOUT=100, LOCKED=0, channel_en=6'b000011 → timeout=1, fail_mask=6'b000011, done about 101 cycles after start.
- channel_en=0 → done one cycle after start, fail_mask=0. Reset (rst=0) asserted mid-SETTLE → next cycle all outputs at reset values, FSM in IDLE.
- start re-pulsed while busy → ignored; sweep result is identical to the single-start run.
